cc_punct_enc: RTL

Parametrised convolutional encoder with puncturing and zero-tail flushing. It is the successor to the fixed-rate `cc` stage inside the FEC chain, and sits after the RS encoder (or directly after the randomizer when RS is bypassed). It accepts one data bit per handshake and emits the rate-1/2 mother-code bits (X, Y) through a 1-to-2-bit output serializer. Supported rates are 1/2, 2/3, 3/4 and 5/6. At the end of each burst the encoder appends K-1 zero tail bits itself, so upstream logic need not insert the tail byte.

---
 rtl/fec_pkg.sv | 54 +++++
 rtl/cc_mother_enc.sv | 49 ++++
 rtl/cc_punct_enc.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/fec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fec_pkg
// Description : Shared constants for the FEC chain: rate codes, puncture
//               tables and default convolutional code parameters.
// Revision    : 1.0 - initial release
// ============================================================================
package fec_pkg;

    localparam int         K_DEFAULT  = 7;
    localparam logic [6:0] G1_DEFAULT = 7'o171;
    localparam logic [6:0] G2_DEFAULT = 7'o133;

    localparam logic [1:0] RATE_1_2 = 2'd0;
    localparam logic [1:0] RATE_2_3 = 2'd1;
    localparam logic [1:0] RATE_3_4 = 2'd2;
    localparam logic [1:0] RATE_5_6 = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_TAIL = 2'd2
    } enc_state_e;

    function automatic logic [2:0] punct_period(input logic [1:0] rate);
        case (rate)
            RATE_1_2: punct_period = 3'd1;
            RATE_2_3: punct_period = 3'd2;
            RATE_3_4: punct_period = 3'd3;
            default:  punct_period = 3'd5;
        endcase
    endfunction

    // Masks are indexed by puncture phase; bit p set means keep at phase p.
    function automatic logic [4:0] keep_x_mask(input logic [1:0] rate);
        case (rate)
            RATE_1_2: keep_x_mask = 5'b00001;
            RATE_2_3: keep_x_mask = 5'b00001;
            RATE_3_4: keep_x_mask = 5'b00101;
            default:  keep_x_mask = 5'b10101;
        endcase
    endfunction

    function automatic logic [4:0] keep_y_mask(input logic [1:0] rate);
        case (rate)
            RATE_1_2: keep_y_mask = 5'b00001;
            RATE_2_3: keep_y_mask = 5'b00011;
            RATE_3_4: keep_y_mask = 5'b00011;
            default:  keep_y_mask = 5'b01011;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/cc_mother_enc.sv
`default_nettype none
// ============================================================================
// Module      : cc_mother_enc
// Description : Rate-1/2 mother convolutional code: shift register and X/Y
//               parity. clear makes the current bit see an all-zero history.
// Revision    : 1.0 - initial release
// ============================================================================
module cc_mother_enc
    import fec_pkg::*;
#(
    parameter int         K  = K_DEFAULT,
    parameter logic [K-1:0] G1 = G1_DEFAULT,
    parameter logic [K-1:0] G2 = G2_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic in_bit,
    input  logic load,
    input  logic clear,
    output logic x_bit,
    output logic y_bit
);

    logic [K-2:0] sr_q;
    logic [K-2:0] sr_d;
    logic [K-2:0] sr_eff;
    logic [K-1:0] vec;

    always_comb begin
        sr_eff = clear ? '0 : sr_q;
        vec    = {in_bit, sr_eff};
        x_bit  = ^(G1 & vec);
        y_bit  = ^(G2 & vec);
        sr_d   = sr_q;
        if (load) begin
            sr_d = {in_bit, sr_eff[K-2:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cc_punct_enc.sv
`default_nettype none
// ============================================================================
// Module      : cc_punct_enc
// Description : Punctured convolutional encoder with zero-tail flushing and a
//               two-entry output serializer.
// Revision    : 1.0 - initial release
// ============================================================================
module cc_punct_enc
    import fec_pkg::*;
#(
    parameter int         K  = K_DEFAULT,
    parameter logic [K-1:0] G1 = G1_DEFAULT,
    parameter logic [K-1:0] G2 = G2_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_bit,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    input  logic [1:0] rate,
    output logic       out_bit,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       busy
);

    localparam int            TW        = $clog2(K);
    localparam logic [TW-1:0] TAIL_LAST = TW'(K - 2);
    localparam logic [TW-1:0] TAIL_DONE = TW'(K - 1);

    enc_state_e    state_q, state_d;
    logic [1:0]    rate_q, rate_d;
    logic [2:0]    phase_q, phase_d;
    logic [TW-1:0] tail_q, tail_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [1:0]    buf_q, buf_d;
    logic [1:0]    lst_q, lst_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;

    logic       buf_ok, data_enc, tail_enc, enc, first, enc_bit, is_last, pop;
    logic [1:0] cur_rate;
    logic [2:0] cur_phase, phase_inc, phase_nxt;
    logic [4:0] x_mask, y_mask;
    logic       keep_x, keep_y;
    logic       x_bit, y_bit;

    // Control terms; kept apart from the datapath block so the parity path
    // through the sub-module does not form a block-level loop.
    always_comb begin
        buf_ok    = (cnt_q == 2'd0) || ((cnt_q == 2'd1) && out_ready);
        in_ready  = !reset && (state_q != ST_TAIL) && buf_ok;
        data_enc  = in_valid && in_ready;
        first     = data_enc && (state_q == ST_IDLE);
        tail_enc  = (state_q == ST_TAIL) && buf_ok && (tail_q != TAIL_DONE);
        enc       = data_enc || tail_enc;
        enc_bit   = data_enc ? in_bit : 1'b0;
        is_last   = tail_enc && (tail_q == TAIL_LAST);
        pop       = out_valid_q && out_ready;
        cur_rate  = first ? rate : rate_q;
        cur_phase = first ? 3'd0 : phase_q;
        x_mask    = keep_x_mask(cur_rate);
        y_mask    = keep_y_mask(cur_rate);
        keep_x    = x_mask[cur_phase];
        keep_y    = y_mask[cur_phase];
        phase_inc = cur_phase + 3'd1;
        phase_nxt = (phase_inc == punct_period(cur_rate)) ? 3'd0 : phase_inc;
    end

    cc_mother_enc #(
        .K  (K),
        .G1 (G1),
        .G2 (G2)
    ) u_mother (
        .clk    (clk),
        .reset  (reset),
        .in_bit (enc_bit),
        .load   (enc),
        .clear  (first),
        .x_bit  (x_bit),
        .y_bit  (y_bit)
    );

    always_comb begin
        state_d = state_q;
        rate_d  = rate_q;
        phase_d = phase_q;
        tail_d  = tail_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        lst_d   = lst_q;

        // Encoding only happens once the buffer is (or is about to be) empty,
        // so a load always overwrites both entries.
        if (enc) begin
            phase_d = phase_nxt;
            if (keep_x && keep_y) begin
                buf_d = {y_bit, x_bit};
                lst_d = {is_last, 1'b0};
                cnt_d = 2'd2;
            end else begin
                buf_d = {1'b0, (keep_x ? x_bit : y_bit)};
                lst_d = {1'b0, is_last};
                cnt_d = 2'd1;
            end
        end else if (pop) begin
            buf_d = {1'b0, buf_q[1]};
            lst_d = {1'b0, lst_q[1]};
            cnt_d = cnt_q - 2'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (first) begin
                    rate_d  = rate;
                    tail_d  = '0;
                    busy_d  = 1'b1;
                    state_d = in_last ? ST_TAIL : ST_DATA;
                end
            end
            ST_DATA: begin
                if (data_enc && in_last) begin
                    state_d = ST_TAIL;
                end
            end
            ST_TAIL: begin
                if (tail_enc) begin
                    tail_d = tail_q + TW'(1);
                end
                if (pop && lst_q[0]) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    tail_d  = '0;
                    phase_d = 3'd0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        out_valid_d = (cnt_d != 2'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rate_q      <= RATE_1_2;
            phase_q     <= 3'd0;
            tail_q      <= '0;
            cnt_q       <= 2'd0;
            buf_q       <= 2'b00;
            lst_q       <= 2'b00;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rate_q      <= rate_d;
            phase_q     <= phase_d;
            tail_q      <= tail_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            lst_q       <= lst_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign out_bit   = buf_q[0];
    assign out_last  = lst_q[0];
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire
